change_dispenser: RTL

- Payout end of the vending machine: consumes the machine's per-transaction result (purchase flag plus 2-bit cash_return code) and drives the product-release and coin-ejection mechanism.
- Pays change one coin at a time over a request/acknowledge handshake with the coin hopper.
- Tracks on-board 5tk and 10tk coin inventory.
- Substitutes two 5tk coins when no 10tk coin is available, and flags short change when inventory cannot cover the amount.

---
 rtl/change_dispenser_if.sv | 36 +++
 rtl/change_dispenser.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// Payout-side bundle between the vending controller, the coin hopper and the dispenser.
// Combinational only: it carries wires and adds no latency.
// The hopper paces the dispenser through coin_ack, and busy tells the controller when req is ignored.
interface change_dispenser_if #(
  parameter int CNT_W = 4
);
  logic             req;
  logic             purchase;
  logic [1:0]       cash_return;
  logic             coin_ack;
  logic             refill5;
  logic             refill10;
  logic             busy;
  logic             vend;
  logic             coin5_out;
  logic             coin10_out;
  logic             done;
  logic             short_change;
  logic             fault;
  logic [CNT_W-1:0] c5_count;
  logic [CNT_W-1:0] c10_count;

  // Dispenser side
  modport slave (
    input  req, purchase, cash_return, coin_ack, refill5, refill10,
    output busy, vend, coin5_out, coin10_out, done, short_change, fault,
           c5_count, c10_count
  );

  // Controller / hopper / bench side
  modport master (
    output req, purchase, cash_return, coin_ack, refill5, refill10,
    input  busy, vend, coin5_out, coin10_out, done, short_change, fault,
           c5_count, c10_count
  );
endinterface

// File: rtl/change_dispenser.sv
// Releases the product and pays change one coin at a time from a 5tk/10tk inventory.
// vend comes 1 cycle after req; the first coin request comes 2 cycles after req (3 cycles with a purchase).
// Each coin is held until coin_ack, a silent hopper latches a sticky fault, and req is ignored while busy.
module change_dispenser #(
  parameter int INIT_C5     = 8,
  parameter int INIT_C10    = 4,
  parameter int CNT_W       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  change_dispenser_if.slave    bus
);

  localparam int               TMO_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE, VEND, PAY, WAIT_ACK, DONE, FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;          // change still owed, in units of 5tk
  logic             sel10_q, sel10_d;      // coin currently requested: 1 = 10tk, 0 = 5tk
  logic [TMO_W-1:0] tmo_q, tmo_d;          // cycles spent waiting for coin_ack
  logic             short_q, short_d;
  logic             fault_q, fault_d;
  logic             busy_q, busy_d;
  logic             vend_q, vend_d;
  logic             coin5_q, coin5_d;
  logic             coin10_q, coin10_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] c5_q, c5_d;
  logic [CNT_W-1:0] c10_q, c10_d;
  logic             dec5, dec10;

  // A simultaneous refill and dispense cancel out; refills stop at the counter maximum.
  function automatic logic [CNT_W-1:0] inv_next(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != CNT_MAX) nxt = cur + 1'b1;
    else if (dec && !inc)              nxt = cur - 1'b1;
    return nxt;
  endfunction

  // Next-state logic: transaction sequencing, coin selection and the ack watchdog
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel10_d = sel10_q;
    tmo_d   = tmo_q;
    short_d = short_q;
    fault_d = fault_q;
    dec5    = 1'b0;
    dec10   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          rem_d   = bus.cash_return;
          short_d = 1'b0;
          state_d = bus.purchase ? VEND : PAY;
        end
      end
      VEND: state_d = PAY;
      PAY: begin
        tmo_d = '0;
        if (rem_q == 2'd0) begin
          state_d = DONE;
        end else if (rem_q >= 2'd2 && c10_q != '0) begin
          sel10_d = 1'b1;
          state_d = WAIT_ACK;
        end else if (c5_q != '0) begin
          sel10_d = 1'b0;
          state_d = WAIT_ACK;
        end else begin
          short_d = 1'b1;
          state_d = DONE;
        end
      end
      WAIT_ACK: begin
        if (bus.coin_ack) begin
          if (sel10_q) begin
            dec10 = 1'b1;
            rem_d = rem_q - 2'd2;
          end else begin
            dec5  = 1'b1;
            rem_d = rem_q - 2'd1;
          end
          tmo_d   = '0;
          state_d = PAY;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          tmo_d   = tmo_q + 1'b1;
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so that the registered copies line up with state_q.
    busy_d   = (state_d != IDLE);
    vend_d   = (state_d == VEND);
    coin5_d  = (state_d == WAIT_ACK) && !sel10_d;
    coin10_d = (state_d == WAIT_ACK) &&  sel10_d;
    done_d   = (state_d == DONE);
    c5_d     = inv_next(c5_q,  bus.refill5,  dec5);
    c10_d    = inv_next(c10_q, bus.refill10, dec10);
  end

  // State, counters and registered outputs; reset also aborts any coin in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      sel10_q  <= 1'b0;
      tmo_q    <= '0;
      short_q  <= 1'b0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      vend_q   <= 1'b0;
      coin5_q  <= 1'b0;
      coin10_q <= 1'b0;
      done_q   <= 1'b0;
      c5_q     <= CNT_W'(INIT_C5);
      c10_q    <= CNT_W'(INIT_C10);
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      sel10_q  <= sel10_d;
      tmo_q    <= tmo_d;
      short_q  <= short_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
      vend_q   <= vend_d;
      coin5_q  <= coin5_d;
      coin10_q <= coin10_d;
      done_q   <= done_d;
      c5_q     <= c5_d;
      c10_q    <= c10_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.vend         = vend_q;
  assign bus.coin5_out    = coin5_q;
  assign bus.coin10_out   = coin10_q;
  assign bus.done         = done_q;
  assign bus.short_change = short_q;
  assign bus.fault        = fault_q;
  assign bus.c5_count     = c5_q;
  assign bus.c10_count    = c10_q;

endmodule
